// File: rtl/m_seq_ctrl.sv
// Sequencer and valid/ready front end for the RV32 M-extension unit.
// Multiplies in one compute cycle and divides with a restoring loop plus a sign fix-up.
module m_seq_ctrl #(
  parameter int unsigned EARLY_OUT  = 1,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = $clog2(DIV_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_r;
  logic [XLEN-1:0]   b_r;
  logic [XLEN-1:0]   d_r;
  logic [XLEN-1:0]   q_r;
  logic [XLEN-1:0]   rem_r;
  logic              res_neg;
  logic [CW-1:0]     cnt;

  // Operand conditioning at acceptance
  logic            in_signed_div;
  logic            in_sign_a;
  logic            in_sign_b;
  logic [XLEN-1:0] in_mag_a;
  logic [XLEN-1:0] in_mag_b;
  logic            in_res_neg;

  always_comb begin
    in_signed_div = in_op[2] & ~in_op[0];
    in_sign_a     = in_signed_div & in_a[31];
    in_sign_b     = in_signed_div & in_b[31];
    in_mag_a      = in_sign_a ? (~in_a + 32'd1) : in_a;
    in_mag_b      = in_sign_b ? (~in_b + 32'd1) : in_b;
    in_res_neg    = in_op[1] ? in_sign_a
                             : ((in_sign_a ^ in_sign_b) & (in_b != 32'd0));
  end

  // 33x33 signed product via 64-bit sign/zero-extended operands
  logic            mul_a_ext;
  logic            mul_b_ext;
  logic [63:0]     prod;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    mul_a_ext = (op_r[1:0] == 2'b11) ? 1'b0 : a_r[31];
    mul_b_ext = op_r[1] ? 1'b0 : b_r[31];
    prod      = {{32{mul_a_ext}}, a_r} * {{32{mul_b_ext}}, b_r};
    mul_res   = (op_r[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  end

  // One restoring-division step
  logic [XLEN:0]   r_sh;
  logic            r_ge;
  logic [XLEN-1:0] r_next;
  logic [XLEN-1:0] q_next;

  always_comb begin
    r_sh   = {rem_r, q_r[31]};
    r_ge   = (r_sh >= {1'b0, d_r});
    r_next = r_ge ? 32'(r_sh - {1'b0, d_r}) : r_sh[31:0];
    q_next = {q_r[30:0], r_ge};
  end

  // RISC-V special cases and final sign fix-up
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] early_res;
  logic [XLEN-1:0] fix_res;

  always_comb begin
    div_zero  = (b_r == 32'd0);
    div_ovf   = ~op_r[0] & (a_r == 32'h8000_0000) & (b_r == 32'hFFFF_FFFF);
    early_res = op_r[1] ? (div_zero ? a_r : 32'd0)
                        : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
    if (op_r[1]) fix_res = res_neg ? (~rem_r + 32'd1) : rem_r;
    else         fix_res = res_neg ? (~q_r + 32'd1) : q_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_r       <= 3'd0;
      a_r        <= '0;
      b_r        <= '0;
      d_r        <= '0;
      q_r        <= '0;
      rem_r      <= '0;
      res_neg    <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_r     <= in_op;
            a_r      <= in_a;
            b_r      <= in_b;
            d_r      <= in_mag_b;
            q_r      <= in_mag_a;
            rem_r    <= '0;
            res_neg  <= in_res_neg;
            cnt      <= CW'(DIV_CYCLES);
            state    <= in_op[2] ? S_DIV : S_MUL;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_MUL: begin
          out_result <= mul_res;
          out_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DIV: begin
          if ((EARLY_OUT != 0) && (cnt == CW'(DIV_CYCLES)) && (div_zero || div_ovf)) begin
            out_result <= early_res;
            out_valid  <= 1'b1;
            cnt        <= '0;
            state      <= S_DONE;
          end else begin
            rem_r <= r_next;
            q_r   <= q_next;
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          out_result <= fix_res;
          out_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_seq_ctrl.sv
// Self-checking bench for m_seq_ctrl: two instances (early-out on and off) against
// an arithmetic reference model, with directed corner cases and random operations.
module tb_m_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        iv1, iv0, or1, or0;
  logic        ir1, ir0, ov1, ov0, busy1, busy0;
  logic [31:0] res1, res0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  m_seq_ctrl #(.EARLY_OUT(1), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv1), .in_ready(ir1), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(ov1), .out_ready(or1), .out_result(res1), .busy(busy1)
  );

  m_seq_ctrl #(.EARLY_OUT(0), .DIV_CYCLES(32)) dut_n (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv0), .in_ready(ir0), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(ov0), .out_ready(or0), .out_result(res0), .busy(busy0)
  );

  function automatic logic g_ov(input bit e0);   return e0 ? ov0 : ov1;     endfunction
  function automatic logic g_ir(input bit e0);   return e0 ? ir0 : ir1;     endfunction
  function automatic logic g_busy(input bit e0); return e0 ? busy0 : busy1; endfunction
  function automatic logic [31:0] g_res(input bit e0); return e0 ? res0 : res1; endfunction

  // Reference: RISC-V M semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input bit e0, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (!e0 && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return 34;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and return just after the accepting edge (cycle N+1)
  task automatic send(input bit e0, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_op = op; in_a = a; in_b = b;
    if (e0) iv0 = 1'b1; else iv1 = 1'b1;
    while (!g_ir(e0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk); #1;
    iv0 = 1'b0; iv1 = 1'b0;
    in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
  endtask

  task automatic wait_resp(input bit e0, input string tag, input logic [31:0] exp, input int lat);
    int k = 1;
    while (!g_ov(e0) && k < 60) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, "_valid"}, 32'(g_ov(e0)), 32'd1);
    chk({tag, "_lat"}, 32'(k), 32'(lat));
    chk({tag, "_res"}, g_res(e0), exp);
  endtask

  task automatic handshake(input bit e0);
    if (e0) or0 = 1'b1; else or1 = 1'b1;
    @(posedge clk); #1;
    or0 = 1'b0; or1 = 1'b0;
    chk("hs_valid_drop", 32'(g_ov(e0)), 32'd0);
    chk("hs_in_ready", 32'(g_ir(e0)), 32'd1);
  endtask

  task automatic run(input bit e0, input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    send(e0, op, a, b);
    wait_resp(e0, tag, model(op, a, b), model_lat(e0, op, a, b));
    handshake(e0);
  endtask

  // Abort a DIVU at iteration 15 with flush or reset; no response may follow
  task automatic abort_test(input bit use_reset);
    logic seen = 1'b0;
    send(1'b0, 3'd5, 32'hDEAD_BEEF, 32'd13);
    repeat (14) begin @(posedge clk); #1; end
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0;
    chk(use_reset ? "rst_busy" : "fl_busy", 32'(busy1), 32'd0);
    chk(use_reset ? "rst_ready" : "fl_ready", 32'(ir1), 32'd1);
    if (use_reset) chk("rst_result", res1, 32'd0);
    repeat (30) begin
      seen = seen | ov1;
      @(posedge clk); #1;
    end
    chk(use_reset ? "rst_no_resp" : "fl_no_resp", 32'(seen), 32'd0);
    run(1'b0, use_reset ? "rst_mul" : "fl_mul", 3'd0, 32'd3, 32'd4);
  endtask

  initial begin
    logic [31:0] held, ra, rb;
    logic [2:0]  rop;
    reset = 1'b1; flush = 1'b0;
    iv1 = 1'b0; iv0 = 1'b0; or1 = 1'b0; or0 = 1'b0;
    in_op = 3'd0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov1), 32'd0);
    chk("rst_out_result", res1, 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_in_ready", 32'(ir1), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    run(1'b0, "mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run(1'b0, "mul_neg",  3'd0, 32'hFFFF_FFFF, 32'd2);
    run(1'b0, "mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(1'b0, "mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(1'b0, "div_m7",   3'd4, 32'hFFFF_FFF9, 32'd2);
    run(1'b0, "rem_m7",   3'd6, 32'hFFFF_FFF9, 32'd2);
    run(1'b0, "divu_100", 3'd5, 32'd100, 32'd7);
    for (int e = 0; e < 2; e++) begin
      run(e[0], "div_by0",  3'd4, 32'd5, 32'd0);
      run(e[0], "remu_by0", 3'd7, 32'd5, 32'd0);
      run(e[0], "div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run(e[0], "rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      run(e[0], "rem_negby0", 3'd6, 32'hFFFF_FFF0, 32'd0);
    end

    // Backpressure: result held 10 cycles while a second request waits
    send(1'b0, 3'd5, 32'd1000, 32'd9);
    wait_resp(1'b0, "bp_first", 32'd111, 34);
    held = res1;
    in_op = 3'd0; in_a = 32'd6; in_b = 32'd7; iv1 = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", 32'(ov1), 32'd1);
      chk("bp_result_hold", res1, held);
      chk("bp_in_ready_low", 32'(ir1), 32'd0);
    end
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    chk("bp_hs_valid", 32'(ov1), 32'd0);
    chk("bp_hs_idle", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    iv1 = 1'b0;
    chk("bp_second_accepted", 32'(busy1), 32'd1);
    wait_resp(1'b0, "bp_second", 32'd42, 2);
    handshake(1'b0);

    abort_test(1'b0);
    abort_test(1'b1);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run(i[0], "rnd", rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
